// File: rtl/matrix_cal_frm_ctrl.sv
// Frame sequencer around matrix_cal_top: meters source rows under a per-block credit limit and counts output columns.
// Optional watchdog: define MATRIX_CAL_TIMEOUT_EN.
module matrix_cal_frm_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLK_BEATS    = 8,
  parameter int MAX_INFLIGHT = 2,
  parameter int BLK_CNT_W    = 16,
  parameter int TIMEOUT_CYC  = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frm_start,
  input  logic [BLK_CNT_W-1:0]          frm_blk_num,
  input  logic                          up_vld,
  output logic                          up_rdy,
  input  logic [16*DATA_WIDTH-1:0]      up_data,
  output logic                          src_row_vld,
  input  logic                          src_row_rdy,
  output logic [16*DATA_WIDTH-1:0]      src_row_data,
  input  logic                          tmp_col_vld,
  output logic                          tmp_col_rdy,
  input  logic [16*(DATA_WIDTH+4)-1:0]  tmp_col_data,
  output logic                          dn_vld,
  input  logic                          dn_rdy,
  output logic [16*(DATA_WIDTH+4)-1:0]  dn_data,
  output logic                          frm_busy,
  output logic                          frm_done,
  output logic [BLK_CNT_W-1:0]          blk_out_cnt,
  output logic                          err_timeout
);

  localparam int BEAT_W = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
  localparam int INFL_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [BEAT_W-1:0]    LAST_BEAT = BEAT_W'(BLK_BEATS - 1);
  localparam logic [INFL_W-1:0]    INFL_MAX  = INFL_W'(MAX_INFLIGHT);
  localparam logic [BLK_CNT_W-1:0] BLK_ONE   = BLK_CNT_W'(1);

  if (BLK_BEATS < 2 || MAX_INFLIGHT < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
    $error("matrix_cal_frm_ctrl: unsupported parameter set");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [BLK_CNT_W-1:0]  blk_num_q, blk_num_d;
  logic [BEAT_W-1:0]     in_beat_q, in_beat_d;
  logic [BEAT_W-1:0]     out_beat_q, out_beat_d;
  logic [BLK_CNT_W-1:0]  blk_in_cnt_q, blk_in_cnt_d;
  logic [BLK_CNT_W-1:0]  blk_out_cnt_q, blk_out_cnt_d;
  logic [INFL_W-1:0]     inflight_q, inflight_d;

  logic in_ok, out_ok, in_fire, out_fire;
  logic in_blk_start, in_blk_end, out_blk_end, in_frm_end, out_frm_end;
  logic [BLK_CNT_W-1:0] last_blk;

`ifdef MATRIX_CAL_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT_CYC - 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
`endif

  // Credit is only consulted at a block boundary so a started block always completes.
  assign in_ok  = (state_q == RUN) && ((in_beat_q != '0) || (inflight_q < INFL_MAX));
  assign out_ok = (state_q == RUN) || (state_q == DRAIN);

  assign src_row_vld  = up_vld && in_ok;
  assign up_rdy       = src_row_rdy && in_ok;
  assign src_row_data = up_data;
  assign dn_vld       = tmp_col_vld && out_ok;
  assign tmp_col_rdy  = dn_rdy && out_ok;
  assign dn_data      = tmp_col_data;

  assign in_fire      = up_vld && up_rdy;
  assign out_fire     = dn_vld && dn_rdy;
  assign in_blk_start = in_fire && (in_beat_q == '0);
  assign in_blk_end   = in_fire && (in_beat_q == LAST_BEAT);
  assign out_blk_end  = out_fire && (out_beat_q == LAST_BEAT);
  assign last_blk     = blk_num_q - BLK_ONE;
  assign in_frm_end   = in_blk_end && (blk_in_cnt_q == last_blk);
  assign out_frm_end  = out_blk_end && (blk_out_cnt_q == last_blk);

  assign frm_busy    = (state_q != IDLE);
  assign frm_done    = (state_q == DONE);
  assign blk_out_cnt = blk_out_cnt_q;
`ifdef MATRIX_CAL_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    blk_num_d     = blk_num_q;
    in_beat_d     = in_beat_q;
    out_beat_d    = out_beat_q;
    blk_in_cnt_d  = blk_in_cnt_q;
    blk_out_cnt_d = blk_out_cnt_q;
    inflight_d    = inflight_q;
`ifdef MATRIX_CAL_TIMEOUT_EN
    wdog_d        = wdog_q;
    err_d         = 1'b0;
`endif

    if (in_fire) begin
      in_beat_d = in_blk_end ? '0 : in_beat_q + 1'b1;
      if (in_blk_end) blk_in_cnt_d = blk_in_cnt_q + BLK_ONE;
    end
    if (out_fire) begin
      out_beat_d = out_blk_end ? '0 : out_beat_q + 1'b1;
      if (out_blk_end) blk_out_cnt_d = blk_out_cnt_q + BLK_ONE;
    end

    case ({in_blk_start, out_blk_end})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case (state_q)
      IDLE: begin
        if (frm_start) begin
          blk_num_d     = frm_blk_num;
          in_beat_d     = '0;
          out_beat_d    = '0;
          blk_in_cnt_d  = '0;
          blk_out_cnt_d = '0;
          inflight_d    = '0;
          state_d       = (frm_blk_num != '0) ? RUN : DONE;
        end
      end
      RUN:     if (in_frm_end) state_d = out_frm_end ? DONE : DRAIN;
      DRAIN:   if (out_frm_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef MATRIX_CAL_TIMEOUT_EN
    // Stuck output side with blocks pending: abort the frame without frm_done.
    if (!out_ok || out_fire) begin
      wdog_d = '0;
    end else if (inflight_q != '0) begin
      if (wdog_q == WDOG_LIM) begin
        err_d         = 1'b1;
        state_d       = IDLE;
        wdog_d        = '0;
        in_beat_d     = '0;
        out_beat_d    = '0;
        blk_in_cnt_d  = '0;
        blk_out_cnt_d = '0;
        inflight_d    = '0;
      end else begin
        wdog_d = wdog_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      blk_num_q     <= '0;
      in_beat_q     <= '0;
      out_beat_q    <= '0;
      blk_in_cnt_q  <= '0;
      blk_out_cnt_q <= '0;
      inflight_q    <= '0;
`ifdef MATRIX_CAL_TIMEOUT_EN
      wdog_q        <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      blk_num_q     <= blk_num_d;
      in_beat_q     <= in_beat_d;
      out_beat_q    <= out_beat_d;
      blk_in_cnt_q  <= blk_in_cnt_d;
      blk_out_cnt_q <= blk_out_cnt_d;
      inflight_q    <= inflight_d;
`ifdef MATRIX_CAL_TIMEOUT_EN
      wdog_q        <= wdog_d;
      err_q         <= err_d;
`endif
    end
  end

endmodule
